// File: rtl/vga_pkg.sv
// Shared constants and types for the video-input capture path.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 200;
    localparam int unsigned V_ACTIVE = 600;
    localparam int unsigned FB_DEPTH = H_ACTIVE * V_ACTIVE;
    localparam int unsigned ADDR_W   = 17;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        VSYNC  = 2'd1,
        ACTIVE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/vga_in_sync.sv
// Brings the VGA input bundle into the CLOCK_50 domain and turns the
// incoming pixel clock into a one-cycle pixel strobe.
module vga_in_sync
    import vga_pkg::*;
(
    input  logic   CLOCK_50,
    input  logic   RESET_N,
    input  logic   VGA_CLK,
    input  logic   VGA_HS,
    input  logic   VGA_VS,
    input  logic   VGA_BLANK_N,
    input  pixel_t VGA_RGB,
    output logic   pix_stb,
    output logic   hs,
    output logic   vs,
    output logic   blank_n,
    output pixel_t rgb
);

    logic [27:0] s1_q;
    logic [27:0] s2_q;
    logic        clk_d_q;
    logic [26:0] dat_q;

    // Two-stage synchronizer, VGA_CLK edge detect, and a data register kept
    // in step with the strobe so the FSM sees the sample taken at the edge.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q    <= '0;
            s2_q    <= '0;
            clk_d_q <= 1'b0;
            pix_stb <= 1'b0;
            dat_q   <= '0;
        end else begin
            s1_q    <= {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_RGB};
            s2_q    <= s1_q;
            clk_d_q <= s2_q[27];
            pix_stb <= s2_q[27] & ~clk_d_q;
            dat_q   <= s2_q[26:0];
        end
    end

    assign {hs, vs, blank_n, rgb} = dat_q;

endmodule

// File: rtl/vga_capture.sv
// Video-input writer: walks the active region of an incoming VGA stream and
// writes every active pixel into the framebuffer, reporting frame status.
module vga_capture #(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned ADDR_W   = vga_pkg::ADDR_W
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              VGA_CLK,
    input  logic              VGA_HS,
    input  logic              VGA_VS,
    input  logic              VGA_BLANK_N,
    input  logic [7:0]        VGA_R,
    input  logic [7:0]        VGA_G,
    input  logic [7:0]        VGA_B,
    input  logic              capture_en,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_wdata,
    output logic              frame_done,
    output logic              frame_err,
    output logic              locked
);

    localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_A   = ADDR_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(H_ACTIVE + 1);
    localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(V_ACTIVE + 1);

    logic            pix_stb;
    logic            unused_hs;
    logic            vs;
    logic            blank_n;
    vga_pkg::pixel_t rgb;

    vga_in_sync u_sync (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_RGB     ({VGA_R, VGA_G, VGA_B}),
        .pix_stb     (pix_stb),
        .hs          (unused_hs),
        .vs          (vs),
        .blank_n     (blank_n),
        .rgb         (rgb)
    );

    vga_pkg::cap_state_e state_q, state_d;
    logic [ADDR_W-1:0]   x_q, x_d;
    logic [ADDR_W-1:0]   y_q, y_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                err_q, err_d;
    logic                cap_q, cap_d;
    logic                seen_q, seen_d;
    logic                vs_prev_q, vs_prev_d;
    logic                bl_prev_q, bl_prev_d;
    logic                fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_d;
    logic [23:0]         fb_wdata_d;
    logic                done_d;
    logic                ferr_d;
    logic                locked_d;
    logic                vs_rise, vs_fall, bl_fall;

    // State and output registers; vs_prev resets high so a VS already high at
    // release is not mistaken for a fresh frame start.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= vga_pkg::SEEK;
            x_q        <= '0;
            y_q        <= '0;
            base_q     <= '0;
            err_q      <= 1'b0;
            cap_q      <= 1'b0;
            seen_q     <= 1'b0;
            vs_prev_q  <= 1'b1;
            bl_prev_q  <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            base_q     <= base_d;
            err_q      <= err_d;
            cap_q      <= cap_d;
            seen_q     <= seen_d;
            vs_prev_q  <= vs_prev_d;
            bl_prev_q  <= bl_prev_d;
            fb_we      <= fb_we_d;
            fb_addr    <= fb_addr_d;
            fb_wdata   <= fb_wdata_d;
            frame_done <= done_d;
            frame_err  <= ferr_d;
            locked     <= locked_d;
        end
    end

    // Next state: line close, then pixel write, then frame check on VS rise.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        base_d     = base_q;
        err_d      = err_q;
        cap_d      = cap_q;
        seen_d     = seen_q;
        vs_prev_d  = vs_prev_q;
        bl_prev_d  = bl_prev_q;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr;
        fb_wdata_d = fb_wdata;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        locked_d   = locked;
        vs_rise    = vs & ~vs_prev_q;
        vs_fall    = ~vs & vs_prev_q;
        bl_fall    = ~blank_n & bl_prev_q;

        if (pix_stb) begin
            vs_prev_d = vs;
            bl_prev_d = blank_n;
            unique case (state_q)
                vga_pkg::SEEK: begin
                    if (vs_rise) begin
                        state_d = vga_pkg::VSYNC;
                        cap_d   = capture_en;
                    end
                end
                vga_pkg::VSYNC: begin
                    if (vs_fall) begin
                        state_d = vga_pkg::ACTIVE;
                        x_d     = '0;
                        y_d     = '0;
                        base_d  = '0;
                        err_d   = 1'b0;
                        seen_d  = 1'b0;
                    end
                end
                vga_pkg::ACTIVE: begin
                    if (bl_fall && seen_q) begin
                        if (x_q != H_A) begin
                            err_d = 1'b1;
                        end
                        x_d    = '0;
                        seen_d = 1'b0;
                        if (y_q < V_A) begin
                            base_d = base_q + H_A;
                        end
                        if (y_q < Y_MAX) begin
                            y_d = y_q + 1'b1;
                        end
                    end
                    if (blank_n) begin
                        seen_d = 1'b1;
                        if (y_q < V_A) begin
                            if (x_q < H_A) begin
                                if (cap_q) begin
                                    fb_we_d    = 1'b1;
                                    fb_addr_d  = base_q + x_q;
                                    fb_wdata_d = rgb;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                            if (x_q < X_MAX) begin
                                x_d = x_q + 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (vs_rise) begin
                        if (y_d == V_A && !err_d) begin
                            done_d   = cap_q;
                            locked_d = 1'b1;
                        end else begin
                            ferr_d   = 1'b1;
                            locked_d = 1'b0;
                        end
                        cap_d   = capture_en;
                        state_d = vga_pkg::VSYNC;
                    end
                end
                default: state_d = vga_pkg::SEEK;
            endcase
        end
    end

endmodule

// File: doc/vga_capture.md
# vga_capture

Video-input writer for the framebuffer path: samples a VGA-style stream (pixel clock, HS, VS, BLANK_N, 8-bit R/G/B) arriving from the 10 MHz scan-out timing generator or an external source, and writes each active pixel into the 200×600 24-bit framebuffer RAM through a single write port. Runs entirely in the CLOCK_50 domain and treats the incoming pixel clock as data. Also reports frame completion, geometry errors and lock status.

## Interface
- H_ACTIVE, 200, active pixels per line
- V_ACTIVE, 600, active lines per frame
- ADDR_W, 17, framebuffer address width (must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE)

- CLOCK_50  in  1  system clock; all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- VGA_CLK  in  1  incoming pixel clock; period ≥ 4 CLOCK_50 cycles, high/low each ≥ 2 cycles
- VGA_HS  in  1  hsync, active high
- VGA_VS  in  1  vsync, active high
- VGA_BLANK_N  in  1  high = active video
- VGA_R / VGA_G / VGA_B  in  8 each  pixel colour
- capture_en  in  1  capture enable, sampled only at frame boundary
- fb_we  out  1  framebuffer write strobe, one cycle per pixel
- fb_addr  out  ADDR_W  write address, y·H_ACTIVE + x
- fb_wdata  out  24  {R,G,B}
- frame_done  out  1  one-cycle pulse: clean frame fully written
- frame_err  out  1  one-cycle pulse: frame geometry mismatch
- locked  out  1  high after a clean frame, low after any error

## Operation
- All inputs pass through a 2-FF synchronizer; pixel strobe pix_stb = rising edge of synchronized VGA_CLK (one extra register). HS/VS/BLANK_N/RGB sampled from the same synchronizer stage on pix_stb.
- FSM states: SEEK, VSYNC, ACTIVE.
  - SEEK (reset state): wait for VS rising on a pix_stb → VSYNC.
  - VSYNC: latch capture_en into cap_q on VS rising; on VS falling → ACTIVE with x=0, y=0, line_base=0, err_q=0.
  - ACTIVE: on pix_stb with BLANK_N=1 and y<V_ACTIVE: if x<H_ACTIVE and cap_q, write pixel at line_base+x; x++ (saturating at H_ACTIVE+1; x>H_ACTIVE-1 at write time sets err_q, no write). On BLANK_N falling after ≥1 active pixel in the line: if x≠H_ACTIVE set err_q; y++, line_base += H_ACTIVE, x=0. Active pixels with y≥V_ACTIVE set err_q, no write.
  - ACTIVE, VS rising: if y==V_ACTIVE and !err_q → frame_done pulses only if cap_q, locked=1; else frame_err pulse, locked=0. Latch new cap_q; → VSYNC.
- Address by running add only; no multiplier. fb_addr never exceeds H_ACTIVE·V_ACTIVE-1.
- Simultaneous BLANK_N falling and VS rising on same strobe: line close first, then frame check.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_wdata=0, frame_done=0, frame_err=0, locked=0; FSM=SEEK; counters 0.
- Latency: VGA_CLK rising at input pin → fb_we/fb_addr/fb_wdata valid exactly 4 CLOCK_50 cycles later (2 sync + edge + output register), held 1 cycle.
- frame_done/frame_err asserted 4 cycles after the VGA_CLK edge that samples VS rising; exactly one cycle wide; never both.
- RESET_N assertion mid-frame: outputs clear immediately; after release no write until a full VS high→low pair is seen.
- capture_en changes mid-frame have no effect until next VS rising.

## Structure
- Package vga_pkg: H_ACTIVE, V_ACTIVE, FB_DEPTH, pixel_t (24-bit), capture state enum.
- Sub-module vga_in_sync: 2-FF synchronizer for the 28 input bits plus VGA_CLK rising-edge detector producing pix_stb.

## Test plan
- Nominal frame from 264×628 timing model (VGA_CLK = CLOCK_50/5), capture_en=1, after one sync frame → 120000 writes, fb_addr 0..119999 strictly sequential, data matches model, one frame_done, locked=1.
- Single pixel 24'hA5C3F0 at x=0,y=0: VGA_CLK edge at cycle N → fb_we=1, fb_addr=0, fb_wdata=24'hA5C3F0 at cycle N+4 only.
- Line 10 carries 199 pixels → frame_err pulse at next VS, no frame_done, locked=0; next clean frame → locked=1.
- Line 0 carries 201 pixels → 201st not written (no fb_addr=200 from line 0), frame_err, locked=0.
- capture_en=0 before VS rising → zero writes that frame, no frame_done, locked still 1 for clean geometry; capture_en toggled mid-frame → no effect.
- RESET_N low at y=300 → all outputs 0 same cycle; after release no writes until VS high→low, then writes restart at fb_addr=0.
